// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request, HI/LO write and result bundle between the EX stage
//                and the multi-cycle multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : Multi-cycle multiply/divide unit with architectural HI/LO.
//                Define MULDIV_FAST_MUL_EN for a two-cycle single-multiplier
//                mult/multu path; division is always iterative.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    muldiv_unit_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b_mag;
    logic                 r_b_zero;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_fast_go;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]       w_div_sh;
    logic [WIDTH:0]       w_div_try;
    logic [2*WIDTH-1:0]   w_div_acc;

    logic [WIDTH-1:0]     w_mag_hi;
    logic [WIDTH-1:0]     w_mag_lo;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    // Operand magnitudes; the sign rule is reapplied in FIX.
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   w_fast_a;
    logic [2*WIDTH-1:0]   w_fast_b;
    logic [2*WIDTH-1:0]   w_fast_prod;

    assign w_fast_go   = ~bus.op[1];
    assign w_fast_a    = {{WIDTH{~r_op[0] & r_a[WIDTH-1]}}, r_a};
    assign w_fast_b    = {{WIDTH{~r_op[0] & r_b[WIDTH-1]}}, r_b};
    // Low 2*WIDTH bits of the sign-extended product are exact for both signednesses.
    assign w_fast_prod = w_fast_a * w_fast_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_b <= bus.b;
        end
    end
`else
    assign w_fast_go = 1'b0;
`endif

    // Shift-add step: conditional add into the upper half, then shift right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b_mag} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: remainder holds below the divisor, so WIDTH+1 bits suffice for the trial.
    assign w_div_sh  = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_try = w_div_sh - {1'b0, r_b_mag};
    assign w_div_acc = w_div_try[WIDTH] ? {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_div_try[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_mag_hi = r_acc[2*WIDTH-1:WIDTH];
    assign w_mag_lo = r_acc[WIDTH-1:0];

    always_comb begin
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            if (r_b_zero) begin
                w_res_hi = r_a;
                w_res_lo = '1;
            end else begin
                w_res_lo = r_neg_q ? -w_mag_lo : w_mag_lo;
                w_res_hi = r_neg_r ? -w_mag_hi : w_mag_hi;
            end
        end
`ifdef MULDIV_FAST_MUL_EN
        if (!r_op[1]) begin
            {w_res_hi, w_res_lo} = w_fast_prod;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start) w_next = w_fast_go ? FIX : CALC;
            CALC: if (r_cnt == c_cnt_w'(WIDTH-1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b_mag  <= '0;
            r_b_zero <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_a      <= bus.a;
                        r_b_mag  <= w_b_mag;
                        r_b_zero <= (bus.b == '0);
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_cnt    <= '0;
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                CALC: begin
                    r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                FIX: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = (r_state == DONE);
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed self-checking bench for muldiv_unit (WIDTH=32).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

    localparam int WIDTH   = 32;
    localparam int DIV_LAT = WIDTH + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = WIDTH + 2;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Issue one op, then watch 60 cycles. anom counts busy gaps, HI/LO moving
    // before done, and busy lingering after done.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic we_start, input int poke, input int repulse,
                       input logic [31:0] hold_hi, input logic [31:0] hold_lo,
                       output int lat, output int ndone, output int anom);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        if (we_start) begin
            bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        lat = -1; ndone = 0; anom = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (lat < 0) lat = k;
            end else if (lat < 0) begin
                if (!bus.busy) anom++;
                if (bus.hi !== hold_hi || bus.lo !== hold_lo) anom++;
            end else if (k == lat + 1 && bus.busy) begin
                anom++;
            end
            bus.start = (k == repulse);
            if (k == repulse) begin
                bus.op = 2'b11; bus.a = 32'd9; bus.b = 32'd3;
            end
            bus.hi_we = (k == poke);
            bus.lo_we = (k == poke);
            bus.wdata = 32'h0000_1234;
        end
        bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected 00000000", bus.lo); end
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
    endtask

    task automatic test_mult();
        vec_t v[6];
        int lat, nd, an;
        v[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        v[2] = '{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 32'h0000_0000, 32'h0000_003F};
        v[3] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        v[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        v[5] = '{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
        foreach (v[i]) begin
            run(v[i].op, v[i].a, v[i].b, 1'b0, 0, 0, m_hi, m_lo, lat, nd, an);
            checks++;
            if ({bus.hi, bus.lo} !== {v[i].hi, v[i].lo}) begin
                errors++;
                $display("FAIL mult_%0d result got %h_%h expected %h_%h", i, bus.hi, bus.lo, v[i].hi, v[i].lo);
            end
            checks++;
            if (lat !== MUL_LAT) begin errors++; $display("FAIL mult_%0d latency got %0d expected %0d", i, lat, MUL_LAT); end
            checks++;
            if (nd !== 1 || an !== 0) begin errors++; $display("FAIL mult_%0d handshake got done=%0d anomalies=%0d expected 1/0", i, nd, an); end
            m_hi = v[i].hi; m_lo = v[i].lo;
        end
    endtask

    task automatic test_div();
        vec_t v[6];
        int lat, nd, an;
        v[0] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[1] = '{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
        v[2] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        v[3] = '{2'b11, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        v[4] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0004};
        v[5] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        foreach (v[i]) begin
            run(v[i].op, v[i].a, v[i].b, 1'b0, 0, 0, m_hi, m_lo, lat, nd, an);
            checks++;
            if ({bus.hi, bus.lo} !== {v[i].hi, v[i].lo}) begin
                errors++;
                $display("FAIL div_%0d result got %h_%h expected %h_%h", i, bus.hi, bus.lo, v[i].hi, v[i].lo);
            end
            checks++;
            if (lat !== DIV_LAT) begin errors++; $display("FAIL div_%0d latency got %0d expected %0d", i, lat, DIV_LAT); end
            checks++;
            if (nd !== 1 || an !== 0) begin errors++; $display("FAIL div_%0d handshake got done=%0d anomalies=%0d expected 1/0", i, nd, an); end
            m_hi = v[i].hi; m_lo = v[i].lo;
        end
    endtask

    task automatic test_div_corner();
        vec_t v[5];
        int lat, nd, an;
        v[0] = '{2'b10, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        v[1] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        v[2] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        v[3] = '{2'b11, 32'd0,         32'd0,         32'h0000_0000, 32'hFFFF_FFFF};
        v[4] = '{2'b01, 32'd0,         32'h0001_2345, 32'h0000_0000, 32'h0000_0000};
        foreach (v[i]) begin
            run(v[i].op, v[i].a, v[i].b, 1'b0, 0, 0, m_hi, m_lo, lat, nd, an);
            checks++;
            if ({bus.hi, bus.lo} !== {v[i].hi, v[i].lo}) begin
                errors++;
                $display("FAIL corner_%0d result got %h_%h expected %h_%h", i, bus.hi, bus.lo, v[i].hi, v[i].lo);
            end
            checks++;
            if (lat !== (v[i].op[1] ? DIV_LAT : MUL_LAT)) begin
                errors++;
                $display("FAIL corner_%0d latency got %0d expected %0d", i, lat, v[i].op[1] ? DIV_LAT : MUL_LAT);
            end
            checks++;
            if (nd !== 1 || an !== 0) begin errors++; $display("FAIL corner_%0d handshake got done=%0d anomalies=%0d expected 1/0", i, nd, an); end
            m_hi = v[i].hi; m_lo = v[i].lo;
        end
    endtask

    task automatic test_collisions();
        int lat, nd, an;
        // Second start at cycle 10 of a divide must be ignored.
        run(2'b10, 32'd100, 32'd7, 1'b0, 0, 10, m_hi, m_lo, lat, nd, an);
        checks++; if (nd !== 1) begin errors++; $display("FAIL repulse_done_count got %0d expected 1", nd); end
        checks++; if (lat !== DIV_LAT) begin errors++; $display("FAIL repulse_latency got %0d expected %0d", lat, DIV_LAT); end
        checks++; if (an !== 0) begin errors++; $display("FAIL repulse_handshake got %0d anomalies expected 0", an); end
        checks++;
        if ({bus.hi, bus.lo} !== {32'h2, 32'hE}) begin
            errors++; $display("FAIL repulse_result got %h_%h expected 00000002_0000000e", bus.hi, bus.lo);
        end
        m_hi = 32'h2; m_lo = 32'hE;

        // mthi/mtlo at cycle 5 of a busy divide: HI/LO must hold.
        run(2'b11, 32'd100, 32'd7, 1'b0, 5, 0, m_hi, m_lo, lat, nd, an);
        checks++; if (an !== 0 || nd !== 1) begin errors++; $display("FAIL busy_write got done=%0d anomalies=%0d expected 1/0", nd, an); end
        checks++;
        if ({bus.hi, bus.lo} !== {32'h2, 32'hE}) begin
            errors++; $display("FAIL busy_write_result got %h_%h expected 00000002_0000000e", bus.hi, bus.lo);
        end

        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        checks++;
        if ({bus.hi, bus.lo} !== {32'h1234, 32'hE}) begin
            errors++; $display("FAIL mthi_idle got %h_%h expected 00001234_0000000e", bus.hi, bus.lo);
        end

        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_5A5A;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        checks++;
        if ({bus.hi, bus.lo} !== {32'h5A5A, 32'h5A5A}) begin
            errors++; $display("FAIL mthi_mtlo_idle got %h_%h expected 00005a5a_00005a5a", bus.hi, bus.lo);
        end
        m_hi = 32'h5A5A; m_lo = 32'h5A5A;

        // start and writes in the same cycle: the writes are dropped.
        run(2'b01, 32'd3, 32'd4, 1'b1, 0, 0, m_hi, m_lo, lat, nd, an);
        checks++; if (an !== 0 || nd !== 1) begin errors++; $display("FAIL start_vs_write got done=%0d anomalies=%0d expected 1/0", nd, an); end
        checks++;
        if ({bus.hi, bus.lo} !== {32'h0, 32'hC}) begin
            errors++; $display("FAIL start_vs_write_result got %h_%h expected 00000000_0000000c", bus.hi, bus.lo);
        end
        m_hi = 32'h0; m_lo = 32'hC;
    endtask

    task automatic test_reset_mid();
        int lat, nd, an;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b expected 0", bus.done); end
        checks++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            errors++; $display("FAIL midreset_hilo got %h_%h expected 00000000_00000000", bus.hi, bus.lo);
        end
        nd = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_quiet got %0d active cycles expected 0", nd); end
        m_hi = '0; m_lo = '0;

        run(2'b01, 32'd6, 32'd7, 1'b0, 0, 0, m_hi, m_lo, lat, nd, an);
        checks++;
        if ({bus.hi, bus.lo} !== {32'h0, 32'h2A}) begin
            errors++; $display("FAIL after_reset_result got %h_%h expected 00000000_0000002a", bus.hi, bus.lo);
        end
        checks++;
        if (lat !== MUL_LAT || nd !== 1 || an !== 0) begin
            errors++; $display("FAIL after_reset_handshake got lat=%0d done=%0d anomalies=%0d expected %0d/1/0", lat, nd, an, MUL_LAT);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_collisions();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
